// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the decode stage.
// Holds opcode constants plus the ImmSrc, ALUOp and ALUControl encodings
// used by control decode, immediate extension and the ALU.
package riscv_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10
  } immSrc_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluOp_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } aluCtrl_t;

endpackage

// File: rtl/decode_cycle_reg_file.sv
// reg_file: 32x32 integer register file for the decode stage.
// Ports: clk/rst (async active-high clear of all registers), A1/A2 read
// addresses with combinational RD1/RD2, A3/WE3/WD3 write port.
// x0 always reads zero and ignores writes. A read of the register being
// written this cycle returns WD3 directly, so W and D can overlap without
// a stall.
module reg_file
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [4:0]  A3,
  input  logic        WE3,
  input  logic [31:0] WD3,
  output logic [31:0] RD1,
  output logic [31:0] RD2
);

  logic [31:0] regs [32];
  logic        wrValid;

  assign wrValid = WE3 && (A3 != 5'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wrValid) begin
      regs[A3] <= WD3;
    end
  end

  always_comb begin
    RD1 = '0;
    if (A1 != 5'd0) RD1 = (wrValid && (A3 == A1)) ? WD3 : regs[A1];
  end

  always_comb begin
    RD2 = '0;
    if (A2 != 5'd0) RD2 = (wrValid && (A3 == A2)) ? WD3 : regs[A2];
  end

endmodule

// File: rtl/decode_cycle.sv
// decode_cycle: ID stage of the five-stage RV32I pipeline.
// Inputs: IF/ID values (InstrD, PCD, PCPlus4D), FlushE bubble request and
// the W-stage write-back port (RegWriteW, RDW, ResultW).
// Outputs: ID/EX register contents -- controls, ALU op, rs1/rs2 data,
// extended immediate, rd/rs1/rs2 indices and PC values.
// Unrecognised opcodes decode to all-zero controls (a bubble).
module decode_cycle
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        FlushE,
  input  logic        RegWriteW,
  input  logic [4:0]  RDW,
  input  logic [31:0] ResultW,
  output logic        RegWriteE,
  output logic        ALUSrcE,
  output logic        MemWriteE,
  output logic        ResultSrcE,
  output logic        BranchE,
  output logic [2:0]  ALUControlE,
  output logic [31:0] RD1_E,
  output logic [31:0] RD2_E,
  output logic [31:0] Imm_Ext_E,
  output logic [4:0]  RD_E,
  output logic [4:0]  RS1_E,
  output logic [4:0]  RS2_E,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        regWriteD, aluSrcD, memWriteD, resultSrcD, branchD;
  immSrc_t     immSrcD;
  aluOp_t      aluOpD;
  aluCtrl_t    aluCtrlD;
  logic [31:0] immExtD, rd1D, rd2D;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];

  reg_file u_regFile (
    .clk (clk),
    .rst (rst),
    .A1  (InstrD[19:15]),
    .A2  (InstrD[24:20]),
    .A3  (RDW),
    .WE3 (RegWriteW),
    .WD3 (ResultW),
    .RD1 (rd1D),
    .RD2 (rd2D)
  );

  always_comb begin
    regWriteD  = 1'b0;
    aluSrcD    = 1'b0;
    memWriteD  = 1'b0;
    resultSrcD = 1'b0;
    branchD    = 1'b0;
    immSrcD    = IMM_I;
    aluOpD     = ALUOP_ADD;
    case (opcode)
      OP_LW: begin
        regWriteD  = 1'b1;
        aluSrcD    = 1'b1;
        resultSrcD = 1'b1;
      end
      OP_SW: begin
        memWriteD = 1'b1;
        aluSrcD   = 1'b1;
        immSrcD   = IMM_S;
      end
      OP_RTYPE: begin
        regWriteD = 1'b1;
        aluOpD    = ALUOP_FUNCT;
      end
      OP_IALU: begin
        regWriteD = 1'b1;
        aluSrcD   = 1'b1;
        aluOpD    = ALUOP_FUNCT;
      end
      OP_BEQ: begin
        branchD = 1'b1;
        immSrcD = IMM_B;
        aluOpD  = ALUOP_SUB;
      end
      default: ;
    endcase
  end

  // funct7[5] means sub only for R-type; for I-ALU bit 30 is immediate data.
  always_comb begin
    aluCtrlD = ALU_ADD;
    case (aluOpD)
      ALUOP_SUB: aluCtrlD = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          3'b000:  if (opcode[5] && InstrD[30]) aluCtrlD = ALU_SUB;
          3'b010:  aluCtrlD = ALU_SLT;
          3'b110:  aluCtrlD = ALU_OR;
          3'b111:  aluCtrlD = ALU_AND;
          default: aluCtrlD = ALU_ADD;
        endcase
      end
      default: aluCtrlD = ALU_ADD;
    endcase
  end

  always_comb begin
    case (immSrcD)
      IMM_S:   immExtD = {{20{InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
      IMM_B:   immExtD = {{20{InstrD[31]}}, InstrD[7], InstrD[30:25], InstrD[11:8], 1'b0};
      default: immExtD = {{20{InstrD[31]}}, InstrD[31:20]};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || FlushE) begin
      RegWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      MemWriteE   <= 1'b0;
      ResultSrcE  <= 1'b0;
      BranchE     <= 1'b0;
      ALUControlE <= '0;
      RD1_E       <= '0;
      RD2_E       <= '0;
      Imm_Ext_E   <= '0;
      RD_E        <= '0;
      RS1_E       <= '0;
      RS2_E       <= '0;
      PCE         <= '0;
      PCPlus4E    <= '0;
    end else begin
      RegWriteE   <= regWriteD;
      ALUSrcE     <= aluSrcD;
      MemWriteE   <= memWriteD;
      ResultSrcE  <= resultSrcD;
      BranchE     <= branchD;
      ALUControlE <= aluCtrlD;
      RD1_E       <= rd1D;
      RD2_E       <= rd2D;
      Imm_Ext_E   <= immExtD;
      RD_E        <= InstrD[11:7];
      RS1_E       <= InstrD[19:15];
      RS2_E       <= InstrD[24:20];
      PCE         <= PCD;
      PCPlus4E    <= PCPlus4D;
    end
  end

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle: reset, register read-back, main and ALU
// decode, immediate forms, write-through bypass, x0 writes and flush.
module tb_decode_cycle;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] InstrD, PCD, PCPlus4D, ResultW;
  logic        FlushE, RegWriteW;
  logic [4:0]  RDW;
  logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
  logic [2:0]  ALUControlE;
  logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E;
  logic [4:0]  RD_E, RS1_E, RS2_E;

  int unsigned checkCount = 0;
  int unsigned passCount  = 0;
  logic [31:0] pcCnt = 32'h100;
  logic [31:0] lastPc;

  always #5 clk = ~clk;

  decode_cycle dut (
    .clk(clk), .rst(rst), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .FlushE(FlushE), .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
    .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
    .RS1_E(RS1_E), .RS2_E(RS2_E), .PCE(PCE), .PCPlus4E(PCPlus4E)
  );

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic checkCtrl(input string tag, input logic rw, input logic as, input logic mw,
                           input logic rs, input logic br, input logic [2:0] alu);
    checkVal({tag, ".RegWriteE"},   32'(RegWriteE),   32'(rw));
    checkVal({tag, ".ALUSrcE"},     32'(ALUSrcE),     32'(as));
    checkVal({tag, ".MemWriteE"},   32'(MemWriteE),   32'(mw));
    checkVal({tag, ".ResultSrcE"},  32'(ResultSrcE),  32'(rs));
    checkVal({tag, ".BranchE"},     32'(BranchE),     32'(br));
    checkVal({tag, ".ALUControlE"}, 32'(ALUControlE), 32'(alu));
  endtask

  task automatic checkAllZero(input string tag);
    checkCtrl(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    checkVal({tag, ".RD1_E"},     RD1_E,          '0);
    checkVal({tag, ".RD2_E"},     RD2_E,          '0);
    checkVal({tag, ".Imm_Ext_E"}, Imm_Ext_E,      '0);
    checkVal({tag, ".RD_E"},      32'(RD_E),      '0);
    checkVal({tag, ".RS1_E"},     32'(RS1_E),     '0);
    checkVal({tag, ".RS2_E"},     32'(RS2_E),     '0);
    checkVal({tag, ".PCE"},       PCE,            '0);
    checkVal({tag, ".PCPlus4E"},  PCPlus4E,       '0);
  endtask

  // Present one ID-stage cycle at the falling edge; return just after the capture edge.
  task automatic step(input logic [31:0] instr, input logic flush, input logic we,
                      input logic [4:0] rd, input logic [31:0] res);
    @(negedge clk);
    InstrD = instr; FlushE = flush; RegWriteW = we; RDW = rd; ResultW = res;
    PCD = pcCnt; PCPlus4D = pcCnt + 32'd4; lastPc = pcCnt;
    pcCnt = pcCnt + 32'd4;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      InstrD = $urandom; PCD = $urandom; PCPlus4D = $urandom; ResultW = $urandom;
      FlushE = 1'($urandom); RegWriteW = 1'b1; RDW = 5'($urandom);
    end
    #1;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0; FlushE = 1'b0; RegWriteW = 1'b0; InstrD = '0;

    // Write x7, read it back from the array, then lose it to a mid-stream reset.
    step(32'h0000_0000, 1'b0, 1'b1, 5'd7, 32'h0000_1234);
    step(32'h0073_8033, 1'b0, 1'b0, 5'd0, '0);
    checkVal("x7readback.RD1", RD1_E, 32'h0000_1234);
    checkVal("x7readback.RD2", RD2_E, 32'h0000_1234);
    @(negedge clk);
    rst = 1'b1; RegWriteW = 1'b1; RDW = 5'd7; ResultW = 32'hFFFF_FFFF;
    #1;
    checkAllZero("midreset");
    @(negedge clk);
    rst = 1'b0; RegWriteW = 1'b0;

    for (int r = 1; r < 32; r++) begin
      step({7'b0, 5'(r), 5'(r), 3'b000, 5'd0, 7'b0110011}, 1'b0, 1'b0, 5'd0, '0);
      checkVal($sformatf("clr.x%0d.RD1", r), RD1_E, '0);
      checkVal($sformatf("clr.x%0d.RD2", r), RD2_E, '0);
    end

    // addi x5,x0,10
    step(32'h00A0_0293, 1'b0, 1'b0, 5'd0, '0);
    checkCtrl("addi", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    checkVal("addi.Imm", Imm_Ext_E, 32'h0000_000A);
    checkVal("addi.RD", 32'(RD_E), 32'd5);
    checkVal("addi.RS2", 32'(RS2_E), 32'd10);
    checkVal("addi.PCE", PCE, lastPc);
    checkVal("addi.PCPlus4E", PCPlus4E, lastPc + 32'd4);

    // Load x1 and x2 through the write port while decoding bubbles.
    step(32'h0000_0000, 1'b0, 1'b1, 5'd1, 32'h1111_1111);
    step(32'h0000_0000, 1'b0, 1'b1, 5'd2, 32'h2222_2222);

    // sw x2,8(x1)
    step(32'h0020_A423, 1'b0, 1'b0, 5'd0, '0);
    checkCtrl("sw", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000);
    checkVal("sw.Imm", Imm_Ext_E, 32'h0000_0008);
    checkVal("sw.RS1", 32'(RS1_E), 32'd1);
    checkVal("sw.RS2", 32'(RS2_E), 32'd2);
    checkVal("sw.RD1", RD1_E, 32'h1111_1111);
    checkVal("sw.RD2", RD2_E, 32'h2222_2222);

    // beq x1,x2,-4
    step(32'hFE20_8EE3, 1'b0, 1'b0, 5'd0, '0);
    checkCtrl("beq", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001);
    checkVal("beq.Imm", Imm_Ext_E, 32'hFFFF_FFFC);

    // add x4,x3,x3 with same-cycle write-back of x3
    step(32'h0031_8233, 1'b0, 1'b1, 5'd3, 32'hDEAD_BEEF);
    checkCtrl("bypass", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);
    checkVal("bypass.RD1", RD1_E, 32'hDEAD_BEEF);
    checkVal("bypass.RD2", RD2_E, 32'hDEAD_BEEF);
    step(32'h0031_8233, 1'b0, 1'b0, 5'd0, '0);
    checkVal("x3stored.RD1", RD1_E, 32'hDEAD_BEEF);

    // sub x4,x3,x1
    step(32'h4011_8233, 1'b0, 1'b0, 5'd0, '0);
    checkCtrl("sub", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001);
    checkVal("sub.RD2", RD2_E, 32'h1111_1111);
    // addi x5,x0,-1024: bit 30 set but I-type stays add
    step(32'hC000_0293, 1'b0, 1'b0, 5'd0, '0);
    checkCtrl("addiNeg", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000);
    checkVal("addiNeg.Imm", Imm_Ext_E, 32'hFFFF_FC00);
    step(32'h0020_A333, 1'b0, 1'b0, 5'd0, '0);
    checkVal("slt.ALU", 32'(ALUControlE), 32'd5);
    step(32'h0020_E333, 1'b0, 1'b0, 5'd0, '0);
    checkVal("or.ALU", 32'(ALUControlE), 32'd3);
    step(32'h0020_F333, 1'b0, 1'b0, 5'd0, '0);
    checkVal("and.ALU", 32'(ALUControlE), 32'd2);
    step(32'h0020_C333, 1'b0, 1'b0, 5'd0, '0);
    checkVal("xor.ALU", 32'(ALUControlE), 32'd0);

    // Write to x0 is dropped, both as bypass and as stored value.
    step(32'h0000_0033, 1'b0, 1'b1, 5'd0, 32'h0000_0005);
    checkVal("x0wr.RD1", RD1_E, '0);
    step(32'h0000_0033, 1'b0, 1'b0, 5'd0, '0);
    checkVal("x0rd.RD1", RD1_E, '0);
    checkVal("x0rd.RD2", RD2_E, '0);

    // lw x6,4(x1)
    step(32'h0040_A303, 1'b0, 1'b0, 5'd0, '0);
    checkCtrl("lw", 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'b000);
    checkVal("lw.Imm", Imm_Ext_E, 32'h0000_0004);
    checkVal("lw.RD1", RD1_E, 32'h1111_1111);

    // Flush wins over a valid lw.
    step(32'h0040_A303, 1'b1, 1'b0, 5'd0, '0);
    checkAllZero("flush");

    // Unknown opcode becomes a bubble.
    step(32'h0000_007F, 1'b0, 1'b0, 5'd0, '0);
    checkCtrl("badop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/decode_cycle.md
# decode_cycle

Second pipeline stage of the five-stage RV32I core. Consumes the IF/ID values produced by the fetch stage (`InstrD`, `PCD`, `PCPlus4D`), decodes control, reads the integer register file and extends the immediate. It also accepts the write-back port from the W stage and registers everything into the ID/EX pipeline register that feeds execute.

## Interface
- No parameters; XLEN fixed at 32, 32 architectural registers.

Ports:
- `clk` in 1 — single clock, all state on rising edge.
- `rst` in 1 — asynchronous, active-high reset.
- `InstrD` in 32 — instruction from IF/ID.
- `PCD`, `PCPlus4D` in 32 — PC and PC+4 from IF/ID.
- `FlushE` in 1 — bubble request into ID/EX (taken branch).
- `RegWriteW` in 1, `RDW` in 5, `ResultW` in 32 — write-back port.
- `RegWriteE`, `ALUSrcE`, `MemWriteE`, `ResultSrcE`, `BranchE` out 1 — registered controls.
- `ALUControlE` out 3 — registered ALU op.
- `RD1_E`, `RD2_E` out 32 — registered rs1/rs2 data.
- `Imm_Ext_E` out 32 — registered sign-extended immediate.
- `RD_E`, `RS1_E`, `RS2_E` out 5 — registered `InstrD[11:7]`, `[19:15]`, `[24:20]`.
- `PCE`, `PCPlus4E` out 32 — registered PC values.

## Operation
Main decode, by opcode `InstrD[6:0]`:
- lw `0000011`: RegWrite=1, ALUSrc=1, ResultSrc=1, ImmSrc=I, ALUOp=00.
- sw `0100011`: MemWrite=1, ALUSrc=1, ImmSrc=S, ALUOp=00.
- R-type `0110011`: RegWrite=1, ALUOp=10.
- I-ALU `0010011`: RegWrite=1, ALUSrc=1, ImmSrc=I, ALUOp=10.
- beq `1100011`: Branch=1, ImmSrc=B, ALUOp=01.
- Any other opcode: every control is 0, so the instruction becomes a bubble.

ALU decode:
- ALUOp=00 gives add `000`; ALUOp=01 gives sub `001`.
- ALUOp=10 selects by funct3:
  - `000`: sub when R-type and funct7[5]=1, otherwise add.
  - `010`: slt `101`.
  - `110`: or `011`.
  - `111`: and `010`.
  - Any other funct3: add.

Immediate extension:
- I: sign(31) ## `[31:20]`.
- S: sign ## `[31:25]` ## `[11:7]`.
- B: sign ## `[7]` ## `[30:25]` ## `[11:8]` ## 0.

Register file:
- 32×32; x0 always reads 0.
- Write happens on the rising edge when RegWriteW=1 and RDW≠0.
- Reads are combinational with a write-through bypass: if RegWriteW=1, RDW≠0 and RDW equals rs, the read returns ResultW in the same cycle.

## Timing
- Latency: `InstrD` presented in cycle N appears decoded on the E outputs after the rising edge ending cycle N (1 cycle).
- Reset: while `rst`=1, every output is 0 and all 32 registers are cleared, asynchronously. After deassertion, the first rising edge captures normally.
- FlushE=1 at an edge: the ID/EX register loads all zeros, so the controls give a bubble. Flush has priority over capture.
- Write-back and decode of the same register in the same cycle: the bypass delivers the new value to `RD1_E`/`RD2_E` at the next edge. No extra stall.
- Write to x0: discarded. x0 still reads 0 afterwards.
- Reset asserted mid-stream: in-flight ID/EX contents and register contents are lost, with no partial write.

## Structure
- Shared package `riscv_pkg` holds:
  - Opcode constants (LW, SW, RTYPE, IALU, BEQ).
  - ImmSrc encodings (I=00, S=01, B=10).
  - ALUOp encodings.
  - ALUControl encodings: add 000, sub 001, and 010, or 011, slt 101.
- One sub-module, `reg_file`, holds the register array, x0 rule, write port and bypass.
- Control decode, ALU decode, immediate extension and the ID/EX register live in `decode_cycle`.

## Test plan
- **Reset:** drive `rst`=1 with random inputs → all outputs 0. Then read x1..x31 through R-type decodes → all 0.
- **addi x5,x0,10 (`0x00A00293`):** → RegWriteE=1, ALUSrcE=1, Imm_Ext_E=`0x0000000A`, RD_E=5, ALUControlE=000.
- **sw x2,8(x1) (`0x0020A423`):** → MemWriteE=1, RegWriteE=0, Imm_Ext_E=8, RS1_E=1, RS2_E=2.
- **beq x1,x2,-4 (`0xFE208EE3`):** → BranchE=1, ALUControlE=001, Imm_Ext_E=`0xFFFFFFFC`.
- **Bypass:** RegWriteW=1, RDW=3, ResultW=`0xDEADBEEF` in the same cycle as add x4,x3,x3 (`0x00318233`) → RD1_E=RD2_E=`0xDEADBEEF`.
- **x0 write:** RegWriteW=1, RDW=0, ResultW=5, then read x0 → 0.
- **Flush:** FlushE=1 with a valid lw in `InstrD` → next cycle RegWriteE=MemWriteE=ResultSrcE=0.
